aes_wb_queue: RTL

Wishbone slave front end for a block-cipher core; generalises the single-block AES control path to a parametrised block width and a multi-block input queue. Software writes plaintext words into a staging register, and each completed block is pushed into a FIFO that feeds the core through a valid/ready handshake. A single result register captures core output, with sticky error flags and an interrupt. The block sits directly behind the project wrapper's Wishbone port, and its `irq_o` drives `irq[0]`.

---
 rtl/aes_wb_queue.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aes_wb_queue.sv
// Wishbone slave that stages plaintext words, queues complete blocks for a cipher core and captures its results.
// Optional macro AES_WB_QUEUE_COUNT_EN adds a pop/result counter register at offset 0x04.
module aes_wb_queue #(
    parameter int          DATA_W    = 128,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              core_valid_o,
    output logic [DATA_W-1:0] core_block_o,
    input  logic              core_ready_i,
    input  logic              core_result_valid_i,
    input  logic [DATA_W-1:0] core_result_i,
    output logic              irq_o
);
    localparam int WORDS = DATA_W / 32;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PW + 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] stage;
    logic [DATA_W-1:0] stage_d;
    logic [DATA_W-1:0] result;
    logic              out_valid;
    logic              irq_en;
    logic              overflow;
    logic              overrun;
    logic [31:0]       rdata;

    logic [7:0]    off;
    logic [IW-1:0] widx;
    logic hit, aligned, word_ok, is_ctrl, is_stage, is_res;
    logic access, wr, rd, ctrl_wr, flush, clr, st_wr, push, full, push_ok, drop, pop, pop_read;

    assign off     = wbs_adr_i[7:0];
    assign widx    = off[2 +: IW];
    assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign aligned = (off[1:0] == 2'b00);
    assign word_ok = ({1'b0, off[4:2]} < 4'(WORDS));
    assign is_ctrl = hit && (off == 8'h00);
    assign is_stage = hit && aligned && word_ok && (off[7:5] == 3'b001);
    assign is_res   = hit && aligned && word_ok && (off[7:5] == 3'b010);

    // A new access is only taken when ack is low, so strobes held high are acked every other cycle.
    assign access   = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign wr       = access && wbs_we_i;
    assign rd       = access && !wbs_we_i;
    assign ctrl_wr  = wr && is_ctrl && wbs_sel_i[0];
    assign flush    = ctrl_wr && wbs_dat_i[1];
    assign clr      = ctrl_wr && wbs_dat_i[2];
    assign st_wr    = wr && is_stage;
    assign push     = st_wr && (widx == LAST);
    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push && !full;
    assign drop     = push && full;
    assign pop      = core_valid_o && core_ready_i;
    assign pop_read = rd && is_res && (widx == LAST);

    assign core_block_o = mem[rd_ptr];

`ifdef AES_WB_QUEUE_COUNT_EN
    logic [15:0] pop_cnt;
    logic [15:0] res_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || clr) begin
            pop_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (pop)
                pop_cnt <= pop_cnt + 16'd1;
            if (core_result_valid_i)
                res_cnt <= res_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (hit && aligned && (off == 8'h00)) begin
            rdata[0]    = full;
            rdata[1]    = (count == '0);
            rdata[2]    = out_valid;
            rdata[3]    = irq_en;
            rdata[4]    = overflow;
            rdata[5]    = overrun;
            rdata[12:8] = 5'(count);
        end
`ifdef AES_WB_QUEUE_COUNT_EN
        if (hit && (off == 8'h04))
            rdata = {res_cnt, pop_cnt};
`endif
        if (is_res) begin
            for (int i = 0; i < WORDS; i++)
                if (widx == IW'(i))
                    rdata = result[32*i +: 32];
        end
    end

    // Merge the current write's byte lanes so a push on the last word carries that word too.
    always_comb begin
        stage_d = stage;
        for (int i = 0; i < WORDS; i++)
            for (int b = 0; b < 4; b++)
                if (st_wr && (widx == IW'(i)) && wbs_sel_i[b])
                    stage_d[32*i + 8*b +: 8] = wbs_dat_i[8*b +: 8];
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok)
            mem[wr_ptr] <= stage_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            core_valid_o <= 1'b0;
            stage        <= '0;
            result       <= '0;
            out_valid    <= 1'b0;
            irq_en       <= 1'b0;
            overflow     <= 1'b0;
            overrun      <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= rd ? rdata : 32'h0;

            if (ctrl_wr)
                irq_en <= wbs_dat_i[0];

            if (clr) begin
                overflow <= 1'b0;
                overrun  <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
            if (core_result_valid_i && out_valid && !pop_read && !flush)
                overrun <= 1'b1;

            if (flush) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                core_valid_o <= 1'b0;
                stage        <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push_ok);
                rd_ptr <= rd_ptr + PW'(pop);
                count  <= count + CW'(push_ok) - CW'(pop);
                // Valid excludes this cycle's push, so it rises one edge after a push into an empty queue.
                core_valid_o <= ((count - CW'(pop)) != '0);
                if (st_wr)
                    stage <= stage_d;
            end

            if (core_result_valid_i) begin
                result    <= core_result_i;
                out_valid <= 1'b1;
            end else if (pop_read || flush) begin
                out_valid <= 1'b0;
            end

            irq_o <= irq_en && out_valid;
        end
    end

endmodule
